// File: rtl/invader_march.sv
// Invader formation march controller: steps the formation on each accepted tick,
// drops and reverses at the playfield edges, and reloads the march period.
module invader_march #(
  parameter int unsigned X_WIDTH          = 10,
  parameter int unsigned Y_WIDTH          = 9,
  parameter int unsigned X_START          = 16,
  parameter int unsigned Y_START          = 32,
  parameter int unsigned X_MIN            = 8,
  parameter int unsigned X_MAX            = 248,
  parameter int unsigned STEP_X           = 2,
  parameter int unsigned STEP_Y           = 8,
  parameter int unsigned Y_LIMIT          = 200,
  parameter int unsigned ALIVE_WIDTH      = 6,
  parameter int unsigned ALIVE_INIT       = 55,
  parameter int unsigned PERIOD_WIDTH     = 24,
  parameter int unsigned MIN_PERIOD       = 100000,
  parameter int unsigned PERIOD_PER_ALIVE = 20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    restart,
  input  logic [ALIVE_WIDTH-1:0]  alive_count,
  output logic [X_WIDTH-1:0]      x_pos,
  output logic [Y_WIDTH-1:0]      y_pos,
  output logic                    dir,
  output logic                    anim,
  output logic                    stepped,
  output logic                    landed,
  output logic [PERIOD_WIDTH-1:0] period
);

  localparam int unsigned XW1    = X_WIDTH + 1;
  localparam int unsigned YW1    = Y_WIDTH + 1;
  localparam int unsigned PSUM_W = PERIOD_WIDTH + ALIVE_WIDTH + 1;

  typedef enum logic {MARCH, LANDED} state_t;

  state_t                  state, state_nxt;
  logic [X_WIDTH-1:0]      x_nxt;
  logic [Y_WIDTH-1:0]      y_nxt;
  logic                    dir_nxt, anim_nxt, stepped_nxt;
  logic [PERIOD_WIDTH-1:0] period_nxt;

  logic [XW1-1:0] x_right;
  logic           at_right, at_left;
  logic [YW1-1:0] y_sum;

  // Saturating period for a given live-invader count.
  function automatic logic [PERIOD_WIDTH-1:0] calc_period(input logic [ALIVE_WIDTH-1:0] alive);
    logic [PSUM_W-1:0] sum;
    sum = PSUM_W'(MIN_PERIOD) + PSUM_W'(alive) * PSUM_W'(PERIOD_PER_ALIVE);
    if (|sum[PSUM_W-1:PERIOD_WIDTH]) return '1;
    return sum[PERIOD_WIDTH-1:0];
  endfunction

  // Edge tests widened by one bit so they cannot wrap.
  assign x_right  = {1'b0, x_pos} + XW1'(STEP_X);
  assign at_right = x_right > XW1'(X_MAX);
  assign at_left  = {1'b0, x_pos} < XW1'(X_MIN + STEP_X);
  assign y_sum    = {1'b0, y_pos} + YW1'(STEP_Y);

  always_comb begin
    state_nxt   = state;
    x_nxt       = x_pos;
    y_nxt       = y_pos;
    dir_nxt     = dir;
    anim_nxt    = anim;
    stepped_nxt = 1'b0;
    period_nxt  = period;
    if (restart) begin
      state_nxt  = MARCH;
      x_nxt      = X_WIDTH'(X_START);
      y_nxt      = Y_WIDTH'(Y_START);
      dir_nxt    = 1'b1;
      anim_nxt   = 1'b0;
      period_nxt = calc_period(alive_count);
    end else if (tick && run && state == MARCH) begin
      if (dir ? at_right : at_left) begin
        y_nxt   = y_sum[Y_WIDTH-1:0];
        dir_nxt = ~dir;
        if (y_sum >= YW1'(Y_LIMIT)) state_nxt = LANDED;
      end else if (dir) begin
        x_nxt = x_right[X_WIDTH-1:0];
      end else begin
        x_nxt = x_pos - X_WIDTH'(STEP_X);
      end
      anim_nxt    = ~anim;
      stepped_nxt = 1'b1;
      period_nxt  = calc_period(alive_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MARCH;
      x_pos   <= X_WIDTH'(X_START);
      y_pos   <= Y_WIDTH'(Y_START);
      dir     <= 1'b1;
      anim    <= 1'b0;
      stepped <= 1'b0;
      landed  <= 1'b0;
      period  <= calc_period(ALIVE_WIDTH'(ALIVE_INIT));
    end else begin
      state   <= state_nxt;
      x_pos   <= x_nxt;
      y_pos   <= y_nxt;
      dir     <= dir_nxt;
      anim    <= anim_nxt;
      stepped <= stepped_nxt;
      landed  <= (state_nxt == LANDED);
      period  <= period_nxt;
    end
  end

endmodule

// File: tb/tb_invader_march.sv
// Directed bench for invader_march: march, edge drops, landing, period reload/saturation, priority.
module tb_invader_march;

  logic        clk = 1'b0;
  logic        rst, tick, run, restart;
  logic [5:0]  alive_count;
  logic [9:0]  x_pos, x2;
  logic [8:0]  y_pos, y2;
  logic        dir, anim, stepped, landed;
  logic        dir2, anim2, stepped2, landed2;
  logic [23:0] period, period2;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 clk = ~clk;

  invader_march dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .restart(restart),
    .alive_count(alive_count), .x_pos(x_pos), .y_pos(y_pos), .dir(dir),
    .anim(anim), .stepped(stepped), .landed(landed), .period(period)
  );

  // Second instance with a minimum period close to the top of the range.
  invader_march #(.MIN_PERIOD(16777206)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .restart(restart),
    .alive_count(alive_count), .x_pos(x2), .y_pos(y2), .dir(dir2),
    .anim(anim2), .stepped(stepped2), .landed(landed2), .period(period2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      if (stepped === 1'b1) cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; run = 1'b1; restart = 1'b0; alive_count = 6'd55;
    idle(); idle();
    chk("rst_x", 32'(x_pos), 16);
    chk("rst_y", 32'(y_pos), 32);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_anim", 32'(anim), 0);
    chk("rst_stepped", 32'(stepped), 0);
    chk("rst_landed", 32'(landed), 0);
    chk("rst_period", 32'(period), 1200000);
    chk("rst_period_sat", 32'(period2), 16777215);
    rst = 1'b0;

    // March right to the edge.
    tick_n(116, pulses);
    chk("right_x", 32'(x_pos), 248);
    chk("right_y", 32'(y_pos), 32);
    chk("right_dir", 32'(dir), 1);
    chk("right_anim", 32'(anim), 0);
    chk("right_pulses", 32'(pulses), 116);

    tick_n(1, pulses);
    chk("rdrop_x", 32'(x_pos), 248);
    chk("rdrop_y", 32'(y_pos), 40);
    chk("rdrop_dir", 32'(dir), 0);
    chk("rdrop_anim", 32'(anim), 1);
    chk("rdrop_stepped", 32'(stepped), 1);

    tick_n(120, pulses);
    chk("left_x", 32'(x_pos), 8);
    chk("left_dir", 32'(dir), 0);
    tick_n(1, pulses);
    chk("ldrop_x", 32'(x_pos), 8);
    chk("ldrop_y", 32'(y_pos), 48);
    chk("ldrop_dir", 32'(dir), 1);
    chk("ldrop_anim", 32'(anim), 0);

    // Drops 3..21, each a full traverse plus a drop.
    tick_n(19 * 121 - 1, pulses);
    chk("preland_y", 32'(y_pos), 192);
    chk("preland_landed", 32'(landed), 0);
    tick_n(1, pulses);
    chk("land_y", 32'(y_pos), 200);
    chk("land_x", 32'(x_pos), 248);
    chk("land_dir", 32'(dir), 0);
    chk("land_anim", 32'(anim), 1);
    chk("land_landed", 32'(landed), 1);

    tick_n(5, pulses);
    chk("landed_pulses", 32'(pulses), 0);
    chk("landed_hold_y", 32'(y_pos), 200);
    chk("landed_hold_x", 32'(x_pos), 248);
    chk("landed_hold", 32'(landed), 1);

    restart = 1'b1; idle(); restart = 1'b0;
    chk("restart_x", 32'(x_pos), 16);
    chk("restart_y", 32'(y_pos), 32);
    chk("restart_dir", 32'(dir), 1);
    chk("restart_anim", 32'(anim), 0);
    chk("restart_landed", 32'(landed), 0);
    chk("restart_stepped", 32'(stepped), 0);
    chk("sat_restart_x", 32'(x2), 16);
    chk("sat_restart_y", 32'(y2), 32);
    chk("sat_restart_dir", 32'(dir2), 1);
    chk("sat_restart_anim", 32'(anim2), 0);
    chk("sat_restart_landed", 32'(landed2), 0);
    chk("sat_restart_stepped", 32'(stepped2), 0);

    // Period reload on steps only.
    alive_count = 6'd10;
    tick_n(1, pulses);
    chk("per10", 32'(period), 300000);
    chk("per10_sat", 32'(period2), 16777215);
    chk("per10_x", 32'(x_pos), 18);
    alive_count = 6'd0;
    idle();
    chk("per_hold", 32'(period), 300000);
    chk("per_hold_stepped", 32'(stepped), 0);
    tick_n(1, pulses);
    chk("per0", 32'(period), 100000);
    chk("per0_sat", 32'(period2), 16777206);

    // Frozen tick.
    run = 1'b0;
    tick_n(3, pulses);
    chk("frozen_x", 32'(x_pos), 20);
    chk("frozen_anim", 32'(anim), 0);
    chk("frozen_pulses", 32'(pulses), 0);
    run = 1'b1;

    // Restart wins over a coincident tick.
    alive_count = 6'd7;
    restart = 1'b1; tick = 1'b1; idle(); restart = 1'b0; tick = 1'b0;
    chk("rs_tick_x", 32'(x_pos), 16);
    chk("rs_tick_stepped", 32'(stepped), 0);
    chk("rs_tick_period", 32'(period), 240000);

    tick_n(3, pulses);
    chk("mid_x", 32'(x_pos), 22);
    chk("mid_anim", 32'(anim), 1);

    // Reset wins over a coincident tick.
    alive_count = 6'd10;
    rst = 1'b1; tick = 1'b1; idle(); rst = 1'b0; tick = 1'b0;
    chk("rst2_x", 32'(x_pos), 16);
    chk("rst2_y", 32'(y_pos), 32);
    chk("rst2_dir", 32'(dir), 1);
    chk("rst2_anim", 32'(anim), 0);
    chk("rst2_stepped", 32'(stepped), 0);
    chk("rst2_landed", 32'(landed), 0);
    chk("rst2_period", 32'(period), 1200000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
